// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared types and owner-selection helper for cache_arbiter
package cache_arbiter_pkg;

    typedef enum logic [1:0] {
        Idle,
        Lookup,
        Access,
        Hold
    } arb_state_e;

    typedef enum logic {
        Instr,
        Data
    } requester_e;

    // Wide enough for any sensible data-streak limit
    localparam int STREAK_W = 8;

    // Choose the next owner; only meaningful when at least one request is present
    function automatic requester_e pick_owner(
        input logic                i_req,
        input logic                d_req,
        input requester_e          last_grant,
        input logic [STREAK_W-1:0] streak,
        input logic                data_priority,
        input logic [STREAK_W-1:0] max_data_streak
    );
        requester_e owner;
        if (i_req && d_req) begin
            if (data_priority) begin
                // Data normally wins, but yield once the streak limit is reached so fetch cannot starve
                owner = (streak >= max_data_streak) ? Instr : Data;
            end else begin
                owner = (last_grant == Instr) ? Data : Instr;
            end
        end else if (d_req) begin
            owner = Data;
        end else begin
            owner = Instr;
        end
        return owner;
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - fetch/load-store arbiter in front of the single-port unified cache
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int DataPriority  = 1,
    parameter int MaxDataStreak = 4,
    parameter int TimeoutCycles = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        c_enable,
    output logic [31:0] c_address,
    output logic [31:0] c_data_in,
    output logic [3:0]  c_write_enable,
    input  logic [31:0] c_data_out,
    input  logic        c_data_out_ready,
    input  logic        c_busy,
    output logic        err
);

    localparam int                  TW         = $clog2(TimeoutCycles + 1);
    localparam logic [TW-1:0]       TMO_MAX    = TW'(TimeoutCycles);
    localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MaxDataStreak);
    localparam logic                DATA_PRIO  = (DataPriority != 0);

    arb_state_e          state, state_next;
    requester_e          owner_q, last_grant_q, owner_pick;
    logic                grant;
    logic [31:0]         addr_q, wdata_q;
    logic [3:0]          wstrb_q;
    logic [31:0]         i_rdata_q, d_rdata_q;
    logic                err_q;
    logic [STREAK_W-1:0] streak_q;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                in_cycle;

    // Cache-facing signals decode straight from state and latched request fields
    assign in_cycle       = (state == Lookup) || (state == Access);
    assign c_enable       = in_cycle;
    assign c_write_enable = in_cycle ? wstrb_q : 4'b0000;
    assign c_address      = addr_q;
    assign c_data_in      = wdata_q;
    assign i_ack          = (state == Hold) && (owner_q == Instr);
    assign d_ack          = (state == Hold) && (owner_q == Data);
    assign i_rdata        = i_rdata_q;
    assign d_rdata        = d_rdata_q;
    assign err            = err_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= Idle;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and owner selection; requests are only looked at in Idle
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        owner_pick = pick_owner(i_req, d_req, last_grant_q, streak_q, DATA_PRIO, MAX_STREAK);
        case (state)
            Idle: begin
                if (i_req || d_req) begin
                    grant      = 1'b1;
                    state_next = Lookup;
                end
            end
            Lookup:  state_next = Access;
            Access:  if (!c_busy) state_next = Hold;
            Hold:    state_next = Idle;
            default: state_next = Idle;
        endcase
    end

    // Timeout counter holds the number of Access cycles entered so far, saturating
    always_comb begin
        tmo_d = tmo_q;
        if (state == Lookup) begin
            tmo_d = TW'(1);
        end else if ((state == Access) && c_busy && (tmo_q != TMO_MAX)) begin
            tmo_d = tmo_q + 1'b1;
        end else if (state == Hold) begin
            tmo_d = '0;
        end
    end

    // Request latching, streak tracking, read-data capture and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q      <= Instr;
            last_grant_q <= Instr;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            err_q        <= 1'b0;
            streak_q     <= '0;
            tmo_q        <= '0;
        end else begin
            tmo_q <= tmo_d;
            if (grant) begin
                owner_q      <= owner_pick;
                last_grant_q <= owner_pick;
                if (owner_pick == Data) begin
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                    wstrb_q <= d_wstrb;
                    // Streak only grows while fetch is actually waiting
                    if (i_req) begin
                        streak_q <= (streak_q == MAX_STREAK) ? streak_q : streak_q + 1'b1;
                    end else begin
                        streak_q <= '0;
                    end
                end else begin
                    addr_q   <= i_addr;
                    wdata_q  <= '0;
                    wstrb_q  <= 4'b0000;
                    streak_q <= '0;
                end
            end
            if (in_cycle && (tmo_d == TMO_MAX)) begin
                err_q <= 1'b1;
            end
            // Reads complete on the edge that leaves Access; stores leave rdata untouched
            if ((state == Access) && !c_busy && (wstrb_q == 4'b0000)) begin
                if (!c_data_out_ready) begin
                    err_q <= 1'b1;
                end
                if (owner_q == Instr) begin
                    i_rdata_q <= c_data_out;
                end else begin
                    d_rdata_q <= c_data_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter
module tb_cache_arbiter;
    import cache_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_req = 1'b0, d_req = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        i_ack, d_ack;
    logic [31:0] i_rdata, d_rdata;
    logic        c_enable;
    logic [31:0] c_address, c_data_in;
    logic [3:0]  c_write_enable;
    logic [31:0] c_data_out;
    logic        c_data_out_ready = 1'b1;
    logic        c_busy, err;

    logic [31:0] cache_data = '0;
    logic [31:0] busy_n = '0;
    logic [31:0] cnt_en = '0;

    // Cache model: cnt_en is the index of the current Access cycle (0 in Lookup)
    always @(posedge clk) cnt_en <= c_enable ? cnt_en + 32'd1 : 32'd0;
    assign c_busy     = (cnt_en >= 32'd1) && (cnt_en <= busy_n);
    assign c_data_out = cache_data;

    cache_arbiter #(.DataPriority(1), .MaxDataStreak(4), .TimeoutCycles(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .c_enable(c_enable), .c_address(c_address), .c_data_in(c_data_in),
        .c_write_enable(c_write_enable), .c_data_out(c_data_out),
        .c_data_out_ready(c_data_out_ready), .c_busy(c_busy), .err(err)
    );

    logic        b_i_req = 1'b0, b_d_req = 1'b0;
    logic        b_i_ack, b_d_ack, b_c_enable, b_err;
    logic [31:0] b_i_rdata, b_d_rdata, b_c_address, b_c_data_in;
    logic [3:0]  b_c_write_enable;
    logic        b_c_busy, b_ready;
    assign b_c_busy = 1'b0;
    assign b_ready  = 1'b1;

    cache_arbiter #(.DataPriority(0), .MaxDataStreak(4), .TimeoutCycles(16)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .i_req(b_i_req), .i_addr(32'h10), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_addr(32'h20), .d_wdata(32'h0), .d_wstrb(4'h0),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .c_enable(b_c_enable), .c_address(b_c_address), .c_data_in(b_c_data_in),
        .c_write_enable(b_c_write_enable), .c_data_out(b_c_address),
        .c_data_out_ready(b_ready), .c_busy(b_c_busy), .err(b_err)
    );

    int total = 0;
    int bad = 0;
    int overlap_cnt = 0;

    // Both acks high, or an ack alongside c_enable, is never legal
    always @(negedge clk) begin
        if (rst_n && ((i_ack && d_ack) || ((i_ack || d_ack) && c_enable) || (b_i_ack && b_d_ack)))
            overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_data;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          busy;
        logic [31:0] cdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
        logic        chk;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    task automatic run_txn(input vec_t v, input logic ready);
        int   cyc, we_cyc, commits, bus_bad;
        logic got;
        exp_t e;
        @(negedge clk);
        busy_n = v.busy;
        cache_data = v.cdata;
        c_data_out_ready = ready;
        if (v.is_data) begin
            d_req = 1'b1; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
        end else begin
            i_req = 1'b1; i_addr = v.addr; d_wstrb = 4'hF; d_wdata = 32'hFFFF_FFFF;
        end
        sb.push_back('{v.is_data, v.exp_rdata, ready});
        cyc = 0; we_cyc = 0; commits = 0; bus_bad = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (c_enable) begin
                if (c_address !== v.addr) bus_bad++;
                if (c_write_enable !== 4'b0) we_cyc++;
                if (c_write_enable !== 4'b0 && c_write_enable !== v.wstrb) bus_bad++;
                if (v.is_data && v.wstrb != 4'b0 && c_data_in !== v.wdata) bus_bad++;
                if (c_write_enable !== 4'b0 && !c_busy && cnt_en >= 32'd1) commits++;
            end
            if (i_ack || d_ack) got = 1'b1;
        end
        i_req = 1'b0; d_req = 1'b0;
        check("ack_seen", got, 1);
        if (got) begin
            e = sb.pop_front();
            check("ack_port_d", d_ack, e.is_data);
            check("ack_port_i", i_ack, !e.is_data);
            if (e.chk) check("rdata", e.is_data ? d_rdata : i_rdata, e.rdata);
            check("latency", cyc, 3 + v.busy);
            check("we_cycles", we_cyc, (v.is_data && v.wstrb != 4'b0) ? v.busy + 2 : 0);
            check("write_commits", commits, (v.is_data && v.wstrb != 4'b0) ? 1 : 0);
            check("bus_bad", bus_bad, 0);
        end
    endtask

    task automatic wait_ack(output logic got, output int n, input logic on_b);
        got = 1'b0; n = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (on_b ? (b_i_ack || b_d_ack) : (i_ack || d_ack)) got = 1'b1;
        end
    endtask

    initial begin
        logic got;
        int   n;
        logic exp_prio[6];
        logic exp_rr[4];
        vec_t v;

        vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,         4'b0000, 0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h0000_2004, 32'h0000_1234, 4'b0011, 20, 32'h7777_7777, 32'h0};
        vecs[2] = '{1'b1, 32'h0000_0040, 32'h0,         4'b0000, 0,  32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 32'h0000_0104, 32'h0,         4'b0000, 3,  32'h0000_0013, 32'h0000_0013};
        vecs[4] = '{1'b1, 32'h0000_0044, 32'h8765_4321, 4'b1111, 1,  32'h7777_7777, 32'hCAFE_F00D};
        vecs[5] = '{1'b1, 32'h0000_0048, 32'h0,         4'b0000, 5,  32'hA5A5_5A5A, 32'hA5A5_5A5A};
        exp_prio = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_rr   = '{1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_c_enable", c_enable, 0);
        check("rst_c_we", c_write_enable, 0);
        check("rst_c_address", c_address, 0);
        check("rst_c_data_in", c_data_in, 0);
        check("rst_acks", {i_ack, d_ack}, 0);
        check("rst_rdata", i_rdata | d_rdata, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        // Round-robin contention starts with Data after reset
        b_i_req = 1'b1; b_d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(got, n, 1'b1);
            check("rr_ack_seen", got, 1);
            check("rr_grant", b_d_ack, exp_rr[k]);
            if (b_d_ack) check("rr_d_rdata", b_d_rdata, 32'h20);
            else         check("rr_i_rdata", b_i_rdata, 32'h10);
        end
        b_i_req = 1'b0; b_d_req = 1'b0;

        // Table of single transactions
        for (int k = 0; k < 6; k++) run_txn(vecs[k], 1'b1);

        // Data-priority contention with streak guard
        @(negedge clk);
        busy_n = 0; c_data_out_ready = 1'b1; cache_data = 32'h5555_AAAA;
        i_addr = 32'h1000; d_addr = 32'h2000; d_wstrb = 4'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_ack(got, n, 1'b0);
            check("prio_ack_seen", got, 1);
            check("prio_grant", d_ack, exp_prio[k]);
        end
        i_req = 1'b0; d_req = 1'b0;

        // Back-to-back loads with d_req held
        @(negedge clk);
        @(negedge clk);
        cache_data = 32'h0A0A_0A0A; d_addr = 32'h0; d_wstrb = 4'b0; d_req = 1'b1;
        wait_ack(got, n, 1'b0);
        check("b2b_first_lat", n, 3);
        check("b2b_first_data", d_rdata, 32'h0A0A_0A0A);
        d_addr = 32'h4; cache_data = 32'h0B0B_0B0B;
        wait_ack(got, n, 1'b0);
        check("b2b_gap", n, 4);
        check("b2b_second_data", d_rdata, 32'h0B0B_0B0B);
        d_req = 1'b0;

        // Read completing without data_out_ready flags an error
        v = '{1'b0, 32'h0000_0200, 32'h0, 4'b0000, 0, 32'h1111_1111, 32'h0};
        run_txn(v, 1'b0);
        check("ready_err", err, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        c_data_out_ready = 1'b1;
        check("err_cleared", err, 0);

        // Cache hang: err at the 16th Access cycle, no ack, reset recovers
        @(negedge clk);
        busy_n = 32'hFFFF_FFFF; d_addr = 32'h300; d_wstrb = 4'b0; d_req = 1'b1;
        got = 1'b0; n = 0;
        while (n < 60 && cnt_en != 32'd16) begin
            @(negedge clk);
            n++;
            if (i_ack || d_ack) got = 1'b1;
            if (cnt_en == 32'd15) check("tmo_err_early", err, 0);
        end
        check("tmo_reached", cnt_en, 16);
        check("tmo_err", err, 1);
        repeat (10) begin
            @(negedge clk);
            if (i_ack || d_ack) got = 1'b1;
        end
        check("tmo_no_ack", got, 0);
        check("tmo_err_sticky", err, 1);
        rst_n = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("tmo_rst_err", err, 0);
        check("tmo_rst_c_enable", c_enable, 0);
        check("tmo_rst_ack", d_ack, 0);
        rst_n = 1'b1; busy_n = 0;
        repeat (2) @(negedge clk);

        check("ack_overlap", overlap_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
